// File: rtl/sdr_pkg.sv
// Shared modulation types and constellation helpers for the TX chain.
package sdr_pkg;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'b00,
    MOD_QPSK  = 2'b01,
    MOD_16QAM = 2'b10,
    MOD_RSVD  = 2'b11
  } mod_mode_e;

  // Gray-coded 16-QAM axis bit pairs, outer positive level first
  localparam logic [1:0] GRAY_P3 = 2'b00;
  localparam logic [1:0] GRAY_P1 = 2'b01;
  localparam logic [1:0] GRAY_M1 = 2'b11;
  localparam logic [1:0] GRAY_M3 = 2'b10;

  function automatic logic [2:0] bits_per_sym(input mod_mode_e m);
    case (m)
      MOD_BPSK:  return 3'd1;
      MOD_16QAM: return 3'd4;
      default:   return 3'd2;  // reserved mode runs as QPSK
    endcase
  endfunction

endpackage

// File: rtl/qam_sym_lut.sv
// Combinational symbol-to-I/Q lookup; symbol bits are left-aligned in sym.
module qam_sym_lut
  import sdr_pkg::*;
#(
  parameter int unsigned OUT_W  = 12,
  parameter int          A_BPSK = 2047,
  parameter int          A_QPSK = 1447,
  parameter int          A_QAM1 = 647
) (
  input  mod_mode_e                mode,
  input  logic [3:0]               sym,
  output logic signed [OUT_W-1:0]  o_i,
  output logic signed [OUT_W-1:0]  o_q
);

  localparam logic signed [OUT_W-1:0] LVL_BPSK = OUT_W'(A_BPSK);
  localparam logic signed [OUT_W-1:0] LVL_QPSK = OUT_W'(A_QPSK);
  localparam logic signed [OUT_W-1:0] LVL_IN   = OUT_W'(A_QAM1);
  localparam logic signed [OUT_W-1:0] LVL_OUT  = OUT_W'(3 * A_QAM1);

  function automatic logic signed [OUT_W-1:0] qam_axis(input logic [1:0] bits);
    case (bits)
      GRAY_P3: return LVL_OUT;
      GRAY_P1: return LVL_IN;
      GRAY_M1: return -LVL_IN;
      default: return -LVL_OUT;
    endcase
  endfunction

  always_comb begin
    o_i = '0;
    o_q = '0;
    case (mode)
      MOD_BPSK: begin
        o_i = sym[3] ? -LVL_BPSK : LVL_BPSK;
      end
      MOD_16QAM: begin
        o_i = qam_axis(sym[3:2]);
        o_q = qam_axis(sym[1:0]);
      end
      default: begin
        o_i = sym[3] ? -LVL_QPSK : LVL_QPSK;
        o_q = sym[2] ? -LVL_QPSK : LVL_QPSK;
      end
    endcase
  end

endmodule

// File: rtl/qam_mapper.sv
// Word-to-symbol constellation mapper: unpacks DATA_W-bit words MSB-first into
// BPSK/QPSK/16-QAM I/Q samples, one symbol per clock under ready/valid.
module qam_mapper
  import sdr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 12,
  parameter int          A_BPSK = 2047,
  parameter int          A_QPSK = 1447,
  parameter int          A_QAM1 = 647
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [1:0]               i_mode,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_out_ready,
  output logic                     o_valid,
  output logic signed [OUT_W-1:0]  o_I,
  output logic signed [OUT_W-1:0]  o_Q
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  mod_mode_e               mode_q;
  logic [DATA_W-1:0]       word_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           bps;
  logic                    adv;
  logic                    accept;
  logic signed [OUT_W-1:0] lut_i;
  logic signed [OUT_W-1:0] lut_q;

  assign bps     = CW'(bits_per_sym(mode_q));
  assign adv     = !o_valid || i_out_ready;
  // Accepting while the last symbol leaves keeps the output stream gapless
  assign o_ready = !rst && ((count_q == '0) || ((count_q == bps) && adv));
  assign accept  = i_valid && o_ready;

  qam_sym_lut #(
    .OUT_W  (OUT_W),
    .A_BPSK (A_BPSK),
    .A_QPSK (A_QPSK),
    .A_QAM1 (A_QAM1)
  ) u_lut (
    .mode (mode_q),
    .sym  (word_q[DATA_W-1 -: 4]),
    .o_i  (lut_i),
    .o_q  (lut_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_I     <= '0;
      o_Q     <= '0;
      word_q  <= '0;
      count_q <= '0;
      mode_q  <= MOD_QPSK;
    end else begin
      if (adv) begin
        if (count_q != '0) begin
          o_I     <= lut_i;
          o_Q     <= lut_q;
          o_valid <= 1'b1;
          word_q  <= word_q << bps;
          count_q <= count_q - bps;
        end else begin
          o_valid <= 1'b0;
        end
      end
      // Load after the shift so a same-cycle accept overrides the drained buffer
      if (accept) begin
        word_q  <= i_data;
        count_q <= CW'(DATA_W);
        mode_q  <= mod_mode_e'(i_mode);
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
// Scoreboard bench for qam_mapper: directed scenarios plus randomized words and backpressure.
module tb_qam_mapper;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OUT_W  = 12;
  localparam int A_BPSK = 2047;
  localparam int A_QPSK = 1447;
  localparam int A_QAM1 = 647;

  typedef struct {
    int i;
    int q;
  } samp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DATA_W-1:0]       i_data;
  logic [1:0]              i_mode;
  logic                    i_valid;
  logic                    o_ready;
  logic                    i_out_ready;
  logic                    o_valid;
  logic signed [OUT_W-1:0] o_I;
  logic signed [OUT_W-1:0] o_Q;

  samp_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    sym_count = 0;
  bit    rand_bp = 0;
  bit    stall_seen = 0;
  int    held_i, held_q;

  always #5 clk = ~clk;

  qam_mapper #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .A_BPSK (A_BPSK),
    .A_QPSK (A_QPSK),
    .A_QAM1 (A_QAM1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_mode      (i_mode),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_out_ready (i_out_ready),
    .o_valid     (o_valid),
    .o_I         (o_I),
    .o_Q         (o_Q)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Gray axis levels from the constellation table
  function automatic int qam_level(input int bits2);
    case (bits2)
      0: return 3 * A_QAM1;
      1: return A_QAM1;
      3: return -A_QAM1;
      default: return -3 * A_QAM1;
    endcase
  endfunction

  // Reference model: split the word MSB-first into symbols and map each one
  task automatic push_word(input logic [DATA_W-1:0] w, input logic [1:0] m);
    int bps;
    int word;
    int bits;
    samp_t s;
    bps  = (m == 2'd0) ? 1 : (m == 2'd2) ? 4 : 2;
    word = int'(w);
    for (int k = 0; k < int'(DATA_W) / bps; k++) begin
      bits = (word >> (int'(DATA_W) - bps * (k + 1))) % (1 << bps);
      case (bps)
        1: begin s.i = bits ? -A_BPSK : A_BPSK; s.q = 0; end
        2: begin
          s.i = (bits / 2) ? -A_QPSK : A_QPSK;
          s.q = (bits % 2) ? -A_QPSK : A_QPSK;
        end
        default: begin
          s.i = qam_level(bits / 4);
          s.q = qam_level(bits % 4);
        end
      endcase
      exp_q.push_back(s);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send_word(input logic [DATA_W-1:0] w, input logic [1:0] m);
    bit done = 0;
    i_valid = 1'b1;
    i_data  = w;
    i_mode  = m;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (o_ready) begin
        push_word(w, m);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    i_valid = 1'b0;
    i_data  = DATA_W'($urandom);
    i_mode  = 2'($urandom);
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      i_out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  always @(negedge clk) begin
    samp_t e;
    if (rst) begin
      stall_seen = 0;
    end else begin
      if (stall_seen) begin
        check("hold_valid", int'(o_valid), 1);
        check("hold_I", int'(o_I), held_i);
        check("hold_Q", int'(o_Q), held_q);
      end
      if (o_valid && i_out_ready) begin
        sym_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample_I", int'(o_I), e.i);
          check("sample_Q", int'(o_Q), e.q);
        end
      end
      stall_seen = o_valid && !i_out_ready;
      held_i = int'(o_I);
      held_q = int'(o_Q);
    end
  end

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    i_mode = 2'd1;
    i_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_I", int'(o_I), 0);
    check("rst_o_Q", int'(o_Q), 0);
    check("rst_o_ready", int'(o_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_o_ready", int'(o_ready), 1);
    @(posedge clk);
    #1;

    // QPSK table word; o_ready returns only while the 4th symbol is being emitted
    send_word(8'b00_01_10_11, 2'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("qpsk_o_ready_%0d", k), int'(o_ready), (k == 3) ? 1 : 0);
    end
    wait_drain("drain_qpsk");

    // BPSK
    send_word(8'hA5, 2'd0);
    wait_drain("drain_bpsk");

    // Back-to-back 16-QAM words must come out without a bubble
    fork
      begin
        send_word(8'b0011_1001, 2'd2);
        send_word(8'b1101_0110, 2'd2);
      end
      begin
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = o_valid;
        end
        check("qam_first_valid", int'(seen), 1);
        for (int k = 1; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("qam_gapless_%0d", k), int'(o_valid), 1);
        end
      end
    join
    wait_drain("drain_qam");

    // Backpressure mid-word; i_valid held high for a pending word
    send_word(8'b10_11_00_01, 2'd1);
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    i_valid = 1'b1;
    i_data = 8'h3C;
    i_mode = 2'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_o_ready", int'(o_ready), 0);
      check("stall_o_valid", int'(o_valid), 1);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_out_ready = 1'b1;
    wait_drain("drain_stall");

    // Mode changes mid-word: first word stays QPSK, next is 16-QAM
    send_word(8'b11_10_01_00, 2'd1);
    send_word(8'b1000_0111, 2'd2);
    wait_drain("drain_mode_switch");
    check("mode_switch_count", sym_count, 4 + 8 + 4 + 4 + 4 + 2);

    // Reset after two of four QPSK symbols
    send_word(8'b01_10_11_00, 2'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_o_ready", int'(o_ready), 0);
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_o_valid", int'(o_valid), 0);
    check("mid_rst_o_I", int'(o_I), 0);
    check("mid_rst_o_Q", int'(o_Q), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(8'b11_00_01_10, 2'd1);
    wait_drain("drain_after_rst");

    // Randomized words, modes and backpressure
    rand_bp = 1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_word(DATA_W'($urandom), 2'($urandom_range(0, 3)));
    end
    rand_bp = 0;
    @(posedge clk);
    #1;
    i_out_ready = 1'b1;
    wait_drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
